// File: rtl/dc_ipu_filter_weights_if.sv
// rtl/dc_ipu_filter_weights_if.sv - texel/coeff in, texel/weight out handshake bundle of the IPU filter-weight stage
interface dc_ipu_filter_weights_if #(
   parameter int RGB_WIDTH    = 24,
   parameter int COEFF_WIDTH  = 8,
   parameter int WEIGHT_WIDTH = 10
);
   logic                              in_valid;
   logic                              in_ready;
   logic [3:0][3:0][RGB_WIDTH-1:0]    in_texel_matrix;
   logic [COEFF_WIDTH-1:0]            coeff_x;
   logic [COEFF_WIDTH-1:0]            coeff_y;
   logic [1:0]                        mode;
   logic                              out_valid;
   logic                              out_ready;
   logic [3:0][3:0][RGB_WIDTH-1:0]    out_texel_matrix;
   logic [3:0][WEIGHT_WIDTH-1:0]      out_weights_x;
   logic [3:0][WEIGHT_WIDTH-1:0]      out_weights_y;

   modport master (
      output in_valid, in_texel_matrix, coeff_x, coeff_y, mode, out_ready,
      input  in_ready, out_valid, out_texel_matrix, out_weights_x, out_weights_y
   );

   modport slave (
      input  in_valid, in_texel_matrix, coeff_x, coeff_y, mode, out_ready,
      output in_ready, out_valid, out_texel_matrix, out_weights_x, out_weights_y
   );
endinterface

// File: rtl/dc_ipu_filter_weights.sv
// rtl/dc_ipu_filter_weights.sv - 2-stage bubble-free pipe producing nearest/bilinear/point filter weights
module dc_ipu_filter_weights #(
   parameter int RGB_WIDTH          = 24,
   parameter int COEFF_WIDTH        = 8,
   parameter int WEIGHT_WIDTH       = 10,
   parameter int WEIGHT_FRACT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    nreset,
   input  logic                    clr,
   dc_ipu_filter_weights_if.slave  bus
);
   typedef logic [3:0][3:0][RGB_WIDTH-1:0] tex_t;
   typedef logic [3:0][WEIGHT_WIDTH-1:0]   wvec_t;
   typedef logic [WEIGHT_FRACT_WIDTH-1:0]  frac_t;

   localparam logic [WEIGHT_WIDTH-1:0] UNIT = WEIGHT_WIDTH'(1) << WEIGHT_FRACT_WIDTH;

   logic  s1_valid, s2_valid;
   logic  s1_load, s2_load;
   tex_t  s1_tex, s2_tex;
   logic [1:0] s1_mode;
   frac_t s1_fx, s1_fy;
   frac_t fx_n, fy_n;
   wvec_t s2_wx, s2_wy;

   // Fraction alignment: keep the MSBs when the coeff is wider, zero-pad when narrower.
   generate
      if (COEFF_WIDTH >= WEIGHT_FRACT_WIDTH) begin : g_trunc
         assign fx_n = bus.coeff_x[COEFF_WIDTH-1 -: WEIGHT_FRACT_WIDTH];
         assign fy_n = bus.coeff_y[COEFF_WIDTH-1 -: WEIGHT_FRACT_WIDTH];
      end else begin : g_pad
         assign fx_n = {bus.coeff_x, {(WEIGHT_FRACT_WIDTH-COEFF_WIDTH){1'b0}}};
         assign fy_n = {bus.coeff_y, {(WEIGHT_FRACT_WIDTH-COEFF_WIDTH){1'b0}}};
      end
   endgenerate

   // Only the two centre taps ever carry weight; taps 0 and 3 stay zero.
   function automatic wvec_t calc_w(input logic [1:0] m, input frac_t f);
      wvec_t w;
      w = '0;
      case (m)
         2'd1: begin
            w[1] = UNIT - WEIGHT_WIDTH'(f);
            w[2] = WEIGHT_WIDTH'(f);
         end
         2'd2: w[1] = UNIT;
         default: begin
            if (f[WEIGHT_FRACT_WIDTH-1]) w[2] = UNIT;
            else                         w[1] = UNIT;
         end
      endcase
      return w;
   endfunction

   assign s2_load      = !s2_valid || bus.out_ready;
   assign s1_load      = !s1_valid || s2_load;
   assign bus.in_ready = s1_load;

   assign bus.out_valid        = s2_valid;
   assign bus.out_texel_matrix = s2_tex;
   assign bus.out_weights_x    = s2_wx;
   assign bus.out_weights_y    = s2_wy;

   always_ff @(posedge clk) begin
      if (!nreset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s1_tex   <= '0;
         s1_mode  <= '0;
         s1_fx    <= '0;
         s1_fy    <= '0;
         s2_tex   <= '0;
         s2_wx    <= '0;
         s2_wy    <= '0;
      end else if (clr) begin
         // Flush drops both stages and any same-cycle input; data registers hold.
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_tex <= s1_tex;
               s2_wx  <= calc_w(s1_mode, s1_fx);
               s2_wy  <= calc_w(s1_mode, s1_fy);
            end
         end
         if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_tex  <= bus.in_texel_matrix;
               s1_mode <= bus.mode;
               s1_fx   <= fx_n;
               s1_fy   <= fy_n;
            end
         end
      end
   end
endmodule
